poly_frombytes_ctrl: RTL and testbench

Sequencer for the 12-bit coefficient unpacker used in Kyber512 decapsulation state unpacking. It accepts a 384-byte packed polynomial as a stream of 32-bit words and assembles each 12-byte group into the 96-bit unpacker input. The unpacker is instantiated combinationally inside the block. Its 8 coefficients per group are emitted one per handshake, for 256 coefficients per polynomial, with start/done framing. It sits between the AXI-fed input buffer and the NTT/coefficient RAM writer.

---
 rtl/poly_frombytes_ctrl_if.sv | 27 ++
 rtl/poly_frombytes_ctrl.sv | 170 +++++++++++++++++
 tb/tb_poly_frombytes_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/poly_frombytes_ctrl_if.sv
// Stream bundle for poly_frombytes_ctrl: packed 32-bit words in, 12-bit
// coefficients (zero-extended to 16 bits) out.
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both high; while valid is high and ready is low, the unpacker holds
// out_coeff/out_idx/out_last stable.
interface poly_frombytes_ctrl_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_coeff;
  logic [7:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  // Environment side: feeds words, consumes coefficients.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_coeff, out_idx, out_valid, out_last
  );

  // Unpacker side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_coeff, out_idx, out_valid, out_last
  );
endinterface

// File: rtl/poly_frombytes_ctrl.sv
// poly_frombytes_ctrl: gathers 3 packed words into a 96-bit group, unpacks it
// into 8 12-bit coefficients and emits them one per handshake, 32 groups per
// 256-coefficient polynomial.
// Optional macro FROMBYTES_RANGE_CHECK_EN: builds a sticky flag that flags any
// emitted coefficient >= q (3329); without it range_err is tied low.
module poly_frombytes_ctrl (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 range_err,
  output logic [1:0]           dbg_state,
  poly_frombytes_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  word_cnt_q, word_cnt_d;
  logic [2:0]  coef_cnt_q, coef_cnt_d;
  logic [4:0]  grp_cnt_q, grp_cnt_d;
  logic [7:0]  idx_q, idx_d;
  logic [95:0] grp_buf_q, grp_buf_d;

  logic [7:0]  grp_byte [12];
  logic [11:0] slot [8];
  logic [15:0] coeff_s;
  logic        in_ready_s;
  logic        out_valid_s;
  logic        in_acc;
  logic        out_acc;

  // Split the group buffer into bytes, lowest address (word 0, MSB) first.
  always_comb begin
    for (int i = 0; i < 12; i++) begin
      grp_byte[i] = grp_buf_q[95-8*i -: 8];
    end
  end

  // 12-bit unpacker: every three bytes yield an even and an odd coefficient.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      slot[2*j]   = {grp_byte[3*j+1][3:0], grp_byte[3*j]};
      slot[2*j+1] = {grp_byte[3*j+2], grp_byte[3*j+1][7:4]};
    end
  end

  assign coeff_s       = {4'h0, slot[coef_cnt_q]};
  assign in_acc        = in_ready_s & bus.in_valid;
  assign out_acc       = out_valid_s & bus.out_ready;
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_coeff = coeff_s;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = out_valid_s & (idx_q == 8'd255);
  assign busy          = (state_q != IDLE);
  assign dbg_state     = state_q;

  // Next-state, counter and buffer updates plus handshake outputs.
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    coef_cnt_d  = coef_cnt_q;
    grp_cnt_d   = grp_cnt_q;
    idx_d       = idx_q;
    grp_buf_d   = grp_buf_q;
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          word_cnt_d = 2'd0;
          coef_cnt_d = 3'd0;
          grp_cnt_d  = 5'd0;
          idx_d      = 8'd0;
        end
      end
      LOAD: begin
        in_ready_s = 1'b1;
        if (bus.in_valid) begin
          grp_buf_d = {grp_buf_q[63:0], bus.in_data};
          if (word_cnt_q == 2'd2) begin
            word_cnt_d = 2'd0;
            state_d    = EMIT;
          end else begin
            word_cnt_d = word_cnt_q + 2'd1;
          end
        end
      end
      EMIT: begin
        out_valid_s = 1'b1;
        if (bus.out_ready) begin
          coef_cnt_d = coef_cnt_q + 3'd1;
          idx_d      = idx_q + 8'd1;
          if (coef_cnt_q == 3'd7) begin
            if (grp_cnt_q == 5'd31) begin
              state_d = DONE;
            end else begin
              grp_cnt_d = grp_cnt_q + 5'd1;
              state_d   = LOAD;
            end
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and group buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_cnt_q <= 2'd0;
      coef_cnt_q <= 3'd0;
      grp_cnt_q  <= 5'd0;
      idx_q      <= 8'd0;
      grp_buf_q  <= 96'd0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      coef_cnt_q <= coef_cnt_d;
      grp_cnt_q  <= grp_cnt_d;
      idx_q      <= idx_d;
      grp_buf_q  <= grp_buf_d;
    end
  end

`ifdef FROMBYTES_RANGE_CHECK_EN
  logic range_err_q, range_err_d;

  // Sticky flag: cleared by an accepted start, set by an accepted coefficient >= q.
  always_comb begin
    range_err_d = range_err_q;
    if (state_q == IDLE && start) begin
      range_err_d = 1'b0;
    end else if (out_acc && coeff_s >= 16'd3329) begin
      range_err_d = 1'b1;
    end
  end

  // Range flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_err_q <= 1'b0;
    end else begin
      range_err_q <= range_err_d;
    end
  end

  assign range_err = range_err_q;
`else
  assign range_err = 1'b0;
`endif

  logic unused_in_acc;
  assign unused_in_acc = in_acc;

endmodule

// File: tb/tb_poly_frombytes_ctrl.sv
// Bench for poly_frombytes_ctrl: directed word vectors, random gaps and
// stalls, expected coefficients held in a queue and compared per handshake.
`timescale 1ns/1ps
module tb_poly_frombytes_ctrl;

`ifdef FROMBYTES_RANGE_CHECK_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start;
  logic       busy;
  logic       done;
  logic       range_err;
  logic [1:0] dbg_state;

  poly_frombytes_ctrl_if bus ();

  poly_frombytes_ctrl u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .range_err (range_err),
    .dbg_state (dbg_state),
    .bus       (bus.slave)
  );

  // Clock
  always #5 clk = ~clk;

  int          n_tests;
  int          n_fail;
  bit          rmodel;
  logic [31:0] words [96];
  logic [15:0] exp_q [$];
  logic [15:0] hand_grp0 [8] = '{16'h301, 16'h452, 16'h967, 16'hAB8,
                                 16'hFCD, 16'h00E, 16'h000, 16'h000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference unpacking: even = (b0 | b1<<8) & 0xFFF, odd = (b1>>4 | b2<<4) & 0xFFF.
  function automatic void build_expected();
    int b [12];
    exp_q.delete();
    for (int g = 0; g < 32; g++) begin
      for (int w = 0; w < 3; w++) begin
        b[4*w]   = int'(words[3*g+w] >> 24) & 255;
        b[4*w+1] = int'(words[3*g+w] >> 16) & 255;
        b[4*w+2] = int'(words[3*g+w] >> 8) & 255;
        b[4*w+3] = int'(words[3*g+w]) & 255;
      end
      for (int j = 0; j < 4; j++) begin
        exp_q.push_back(16'((b[3*j] | (b[3*j+1] << 8)) & 12'hFFF));
        exp_q.push_back(16'(((b[3*j+1] >> 4) | (b[3*j+2] << 4)) & 12'hFFF));
      end
    end
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_busy"},      32'(busy), 32'd0);
    check({tag, "_done"},      32'(done), 32'd0);
    check({tag, "_in_ready"},  32'(bus.in_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_last"},  32'(bus.out_last), 32'd0);
    check({tag, "_out_coeff"}, 32'(bus.out_coeff), 32'd0);
    check({tag, "_out_idx"},   32'(bus.out_idx), 32'd0);
    check({tag, "_range_err"}, 32'(range_err), 32'd0);
  endtask

  // Runs one polynomial from the words[] / exp_q prepared by the caller.
  // poke_cnt >= 0 pulses start once when that many coefficients are out;
  // abort_words >= 0 returns early once that many words were accepted.
  task automatic stream_poly(input int in_gap, input int out_stall,
                             input int poke_cnt, input int abort_words);
    int          wi;
    int          n_out;
    int          cyc;
    bit          stalled;
    bit          poked;
    bit          acc_in;
    bit          acc_out;
    logic [15:0] prev_coeff;
    logic [7:0]  prev_idx;
    wi = 0; n_out = 0; cyc = 0; stalled = 0; poked = 0;
    prev_coeff = '0; prev_idx = '0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rmodel = 1'b0;
    check("start_in_ready", 32'(bus.in_ready), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    while (n_out < 256 && cyc < 4000) begin
      if (abort_words >= 0 && wi == abort_words) return;
      bus.in_valid  = (wi < 96) && ($urandom_range(0, 99) >= in_gap);
      bus.in_data   = (wi < 96) ? words[wi] : 32'h0;
      bus.out_ready = ($urandom_range(0, 99) >= out_stall);
      start = (poke_cnt >= 0) && !poked && (n_out == poke_cnt);
      if (start) poked = 1'b1;
      check("done_low", 32'(done), 32'd0);
      check("busy_high", 32'(busy), 32'd1);
      check("range_err", 32'(range_err), 32'(rmodel));
      check("ready_excl", 32'(bus.in_ready & bus.out_valid), 32'd0);
      if (stalled) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_coeff", 32'(bus.out_coeff), 32'(prev_coeff));
        check("hold_idx", 32'(bus.out_idx), 32'(prev_idx));
      end
      if (bus.out_valid) begin
        check("coeff", 32'(bus.out_coeff), 32'(exp_q[0]));
        check("idx", 32'(bus.out_idx), n_out);
        check("last", 32'(bus.out_last), 32'(n_out == 255));
      end else begin
        check("last_low", 32'(bus.out_last), 32'd0);
      end
      acc_in     = bus.in_valid && bus.in_ready;
      acc_out    = bus.out_valid && bus.out_ready;
      stalled    = bus.out_valid && !bus.out_ready;
      prev_coeff = bus.out_coeff;
      prev_idx   = bus.out_idx;
      @(posedge clk); #1;
      cyc++;
      if (acc_in) wi++;
      if (acc_out) begin
        if (RC_EN && exp_q[0] >= 16'd3329) rmodel = 1'b1;
        void'(exp_q.pop_front());
        n_out++;
      end
    end
    start = 1'b0;
    check("poly_complete", n_out, 256);
    check("words_used", wi, 96);
    if (in_gap == 0 && out_stall == 0) check("latency", cyc, 352);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd1);
    check("done_out_valid", 32'(bus.out_valid), 32'd0);
    check("done_range_err", 32'(range_err), 32'(rmodel));
    @(posedge clk); #1;
    check("done_clear", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_in_ready", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 96; i++) words[i] = $urandom;
  endtask

  // Main sequence
  initial begin
    n_tests = 0; n_fail = 0; rmodel = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst_n = 1'b1;

    // Words offered while idle must be ignored.
    bus.in_valid = 1'b1; bus.in_data = 32'hDEADBEEF; bus.out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_ignore_ready", 32'(bus.in_ready), 32'd0);
      check("idle_ignore_valid", 32'(bus.out_valid), 32'd0);
    end

    // Basic group as first group of a full, unstalled polynomial.
    words[0] = 32'h01234567; words[1] = 32'h89ABCDEF; words[2] = 32'h00000000;
    for (int i = 3; i < 96; i++) words[i] = 32'(i) * 32'h9E3779B9;
    build_expected();
    for (int i = 0; i < 8; i++) exp_q[i] = hand_grp0[i];
    stream_poly(0, 0, -1, -1);

    // Backpressure with gapped input.
    fill_random();
    build_expected();
    stream_poly(30, 40, -1, -1);

    // All-ones words: every coefficient is 0xFFF.
    for (int i = 0; i < 96; i++) words[i] = 32'hFFFFFFFF;
    build_expected();
    for (int i = 0; i < 256; i++) exp_q[i] = 16'hFFF;
    stream_poly(0, 0, -1, -1);
    check("range_final", 32'(range_err), 32'(RC_EN));

    // start pulsed during group 5 must be ignored.
    fill_random();
    build_expected();
    stream_poly(0, 20, 43, -1);

    // Reset after two words of group 3, then a fresh polynomial.
    fill_random();
    build_expected();
    stream_poly(0, 0, -1, 11);
    rst_n = 1'b0;
    #2;
    check_reset("mid");
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rmodel = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'h12345678;
    @(posedge clk); #1;
    check("post_reset_idle", 32'(bus.in_ready), 32'd0);
    fill_random();
    build_expected();
    stream_poly(10, 10, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
